// File: rtl/hs_rx_multilane_deskew_pkg.sv
// Shared types and helpers for the multi-lane HS receive front end.
package hs_rx_pkg;

  typedef enum logic [1:0] {IDLE, HUNT, ACTIVE, ERR} hs_state_e;

  localparam logic [7:0] SYNC_BYTE_DFLT = 8'hB8;

  function automatic logic [3:0] hamming8(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, a[i] ^ b[i]};
    return n;
  endfunction

endpackage

// File: rtl/hs_rx_multilane_deskew_lane.sv
// One HS lane: sync hunt at either DDR phase, LSB-first byte assembly and a
// small deskew FIFO. The whole lane is cleared whenever run_i is low.
module hs_lane_rx
  import hs_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DFLT,
  parameter int         SOT_ERR_TOL = 1,
  parameter int         SKEW_DEPTH  = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       run_i,
  input  logic [1:0] bits_i,
  input  logic       rd_i,
  output logic       locked_o,
  output logic       err1_o,
  output logic       empty_o,
  output logic       ovf_o,
  output logic [7:0] byte_o
);

  localparam int AW = $clog2(SKEW_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [9:0]  sr_q, sr_d;
  logic        locked_q, phase_q;
  logic [1:0]  cnt_q;
  logic [AW:0] wr_q, rd_q;
  logic [7:0]  mem_q [SKEW_DEPTH];
  logic [7:0]  win_e, win_l, byte_w;
  logic        hit, hit_phase, hit_err, wr, full;

  // Newest bits enter at the top, so sr_q[9] is the latest received bit.
  assign sr_d  = {bits_i[1], bits_i[0], sr_q[9:2]};
  assign win_e = sr_q[8:1];
  assign win_l = sr_q[9:2];

  always_comb begin
    hit       = 1'b0;
    hit_phase = 1'b0;
    hit_err   = 1'b0;
    if (run_i && !locked_q) begin
      if (win_e == SYNC_BYTE) begin
        hit = 1'b1;
      end else if (win_l == SYNC_BYTE) begin
        hit       = 1'b1;
        hit_phase = 1'b1;
      end else if (SOT_ERR_TOL != 0 && hamming8(win_e, SYNC_BYTE) == 4'd1) begin
        hit     = 1'b1;
        hit_err = 1'b1;
      end else if (SOT_ERR_TOL != 0 && hamming8(win_l, SYNC_BYTE) == 4'd1) begin
        hit       = 1'b1;
        hit_phase = 1'b1;
        hit_err   = 1'b1;
      end
    end
  end

  // The byte is taken from the incoming shift value so it lands in the FIFO on its completing edge.
  assign byte_w   = phase_q ? sr_d[9:2] : sr_d[8:1];
  assign wr       = run_i && locked_q && (cnt_q == 2'd3);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o  = (wr_q == rd_q);
  assign ovf_o    = wr && full;
  assign locked_o = locked_q;
  assign err1_o   = hit_err;
  assign byte_o   = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !run_i) begin
      sr_q     <= '0;
      locked_q <= 1'b0;
      phase_q  <= 1'b0;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      sr_q <= sr_d;
      if (hit) begin
        locked_q <= 1'b1;
        phase_q  <= hit_phase;
        cnt_q    <= 2'd1;
      end else if (locked_q) begin
        cnt_q <= cnt_q + 2'd1;
      end
      if (wr && !full) wr_q <= wr_q + PTR_ONE;
      if (rd_i) rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr && !full) mem_q[wr_q[AW-1:0]] <= byte_w;
  end

endmodule

// File: rtl/hs_rx_multilane_deskew.sv
// Multi-lane HS receive front end: burst control FSM, SoT timeout, and
// aligned pop of one byte per lane once every lane FIFO holds data.
module hs_rx_multilane_deskew
  import hs_rx_pkg::*;
#(
  parameter int         LANES        = 1,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DFLT,
  parameter int         SOT_ERR_TOL  = 1,
  parameter int         SKEW_DEPTH   = 4,
  parameter int         SYNC_TIMEOUT = 64
) (
  input  logic                 RxDDRClkHS,
  input  logic                 RST,
  input  logic                 Enable_HS_RX,
  input  logic [2*LANES-1:0]   HS_RX_DATA,
  output logic                 RxActiveHS,
  output logic                 RxSyncHS,
  output logic                 RxValidHS,
  output logic [8*LANES-1:0]   RxDataHS,
  output logic                 ErrSotHS,
  output logic                 ErrSotSyncHS
);

  localparam int TW = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO  = TW'(SYNC_TIMEOUT);
  localparam logic [TW-1:0] TONE = TW'(1);

  hs_state_e            state_q, state_d;
  logic [TW-1:0]        tcnt_q;
  logic                 valid_q, sync_q, err_sot_q, err_seen_q;
  logic [8*LANES-1:0]   data_q, lane_bytes;
  logic [LANES-1:0]     locked, err1, empty, ovf;
  logic                 run, pop, timeout, rx_active, err_sync;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    hs_lane_rx #(
      .SYNC_BYTE  (SYNC_BYTE),
      .SOT_ERR_TOL(SOT_ERR_TOL),
      .SKEW_DEPTH (SKEW_DEPTH)
    ) u_lane (
      .clk_i   (RxDDRClkHS),
      .rst_n_i (RST),
      .run_i   (run),
      .bits_i  (HS_RX_DATA[2*gi +: 2]),
      .rd_i    (pop),
      .locked_o(locked[gi]),
      .err1_o  (err1[gi]),
      .empty_o (empty[gi]),
      .ovf_o   (ovf[gi]),
      .byte_o  (lane_bytes[8*gi +: 8])
    );
  end

  assign pop     = run && !(|empty) && !(|ovf);
  assign timeout = (state_q == HUNT) && (tcnt_q == TMO) && !(&locked);

  always_ff @(posedge RxDDRClkHS) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!Enable_HS_RX) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = HUNT;
        HUNT:    if (|ovf || timeout) state_d = ERR;
                 else if (pop)        state_d = ACTIVE;
        ACTIVE:  if (|ovf) state_d = ERR;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    rx_active = 1'b0;
    err_sync  = 1'b0;
    run       = 1'b0;
    case (state_q)
      HUNT:    run = Enable_HS_RX;
      ACTIVE:  begin rx_active = 1'b1; run = Enable_HS_RX; end
      ERR:     err_sync = 1'b1;
      default: ;
    endcase
  end

  // Data is zeroed on an enable drop so no stale group is left on the bus.
  always_ff @(posedge RxDDRClkHS) begin
    if (!RST) begin
      valid_q    <= 1'b0;
      sync_q     <= 1'b0;
      err_sot_q  <= 1'b0;
      err_seen_q <= 1'b0;
      data_q     <= '0;
      tcnt_q     <= '0;
    end else begin
      valid_q   <= pop;
      sync_q    <= pop && (state_q == HUNT);
      err_sot_q <= run && (|err1) && !err_seen_q;
      if (pop)                data_q <= lane_bytes;
      else if (!Enable_HS_RX) data_q <= '0;
      if (!run)               err_seen_q <= 1'b0;
      else if (|err1)         err_seen_q <= 1'b1;
      if (state_q != HUNT)    tcnt_q <= '0;
      else if (tcnt_q != TMO) tcnt_q <= tcnt_q + TONE;
    end
  end

  assign RxActiveHS   = rx_active;
  assign ErrSotSyncHS = err_sync;
  assign RxSyncHS     = sync_q;
  assign RxValidHS    = valid_q;
  assign RxDataHS     = data_q;
  assign ErrSotHS     = err_sot_q;

endmodule

// File: tb/tb_hs_rx_multilane_deskew.sv
// Directed bench: single-lane (tolerant and strict sync) and two-lane deskew instances.
module tb_hs_rx_multilane_deskew;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en1 = 1'b0, en2 = 1'b0;
  logic [1:0] d1 = '0;
  logic [3:0] d2 = '0;

  logic act1, syn1, val1, esot1, esync1;
  logic [7:0] dat1;
  logic act0, syn0, val0, esot0, esync0;
  logic [7:0] dat0;
  logic act2, syn2, val2, esot2, esync2;
  logic [15:0] dat2;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] DATA [7] = '{8'hCF, 8'h0F, 8'hB0, 8'hFF, 8'h55, 8'h00, 8'hFF};

  bit s1[$], s2a[$], s2b[$];
  logic [7:0]  got1[$];
  int          edg1[$];
  logic        sy1[$], ac1[$];
  logic [15:0] got2[$];
  int          edg2[$];
  int          nerr1, nval0;
  logic        es0 [0:127];
  logic        es1 [0:127];
  logic        es2 [0:127];

  always #5 clk = ~clk;

  hs_rx_multilane_deskew #(.LANES(1), .SOT_ERR_TOL(1)) dut1 (
    .RxDDRClkHS(clk), .RST(rst_n), .Enable_HS_RX(en1), .HS_RX_DATA(d1),
    .RxActiveHS(act1), .RxSyncHS(syn1), .RxValidHS(val1), .RxDataHS(dat1),
    .ErrSotHS(esot1), .ErrSotSyncHS(esync1));

  hs_rx_multilane_deskew #(.LANES(1), .SOT_ERR_TOL(0)) dut0 (
    .RxDDRClkHS(clk), .RST(rst_n), .Enable_HS_RX(en1), .HS_RX_DATA(d1),
    .RxActiveHS(act0), .RxSyncHS(syn0), .RxValidHS(val0), .RxDataHS(dat0),
    .ErrSotHS(esot0), .ErrSotSyncHS(esync0));

  hs_rx_multilane_deskew #(.LANES(2), .SOT_ERR_TOL(1)) dut2 (
    .RxDDRClkHS(clk), .RST(rst_n), .Enable_HS_RX(en2), .HS_RX_DATA(d2),
    .RxActiveHS(act2), .RxSyncHS(syn2), .RxValidHS(val2), .RxDataHS(dat2),
    .ErrSotHS(esot2), .ErrSotSyncHS(esync2));

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic push_bit(input int sel, input bit b);
    case (sel)
      0:       s1.push_back(b);
      1:       s2a.push_back(b);
      default: s2b.push_back(b);
    endcase
  endtask

  function automatic bit pop_bit(input int sel);
    bit b;
    b = 1'b0;
    case (sel)
      0:       if (s1.size() > 0) b = s1.pop_front();
      1:       if (s2a.size() > 0) b = s2a.pop_front();
      default: if (s2b.size() > 0) b = s2b.pop_front();
    endcase
    return b;
  endfunction

  task automatic push_byte(input int sel, input logic [7:0] v);
    for (int i = 0; i < 8; i++) push_bit(sel, v[i]);
  endtask

  task automatic load_lane(input int sel, input int lead, input logic [7:0] syncb);
    for (int i = 0; i < lead; i++) push_bit(sel, 1'b0);
    push_byte(sel, syncb);
    for (int j = 0; j < 7; j++) push_byte(sel, DATA[j]);
  endtask

  task automatic clear_stims();
    s1.delete(); s2a.delete(); s2b.delete();
  endtask

  task automatic capture(input int e);
    if (val1) begin
      got1.push_back(dat1); edg1.push_back(e); sy1.push_back(syn1); ac1.push_back(act1);
    end
    if (esot1) nerr1++;
    if (val0) nval0++;
    if (val2) begin
      got2.push_back(dat2); edg2.push_back(e);
    end
    if (e < 128) begin
      es0[e] = esync0; es1[e] = esync1; es2[e] = esync2;
    end
  endtask

  // Edge k samples the bit pair driven at iteration k; edges 0..n-1 are logged.
  task automatic run_cycles(input int n);
    bit a0, a1, b0, b1;
    got1.delete(); edg1.delete(); sy1.delete(); ac1.delete();
    got2.delete(); edg2.delete();
    nerr1 = 0; nval0 = 0;
    for (int i = 0; i < 128; i++) begin es0[i] = 1'b0; es1[i] = 1'b0; es2[i] = 1'b0; end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k > 0) capture(k - 1);
      a0 = pop_bit(0); a1 = pop_bit(0);
      d1 = {a1, a0};
      a0 = pop_bit(1); a1 = pop_bit(1);
      b0 = pop_bit(2); b1 = pop_bit(2);
      d2 = {b1, b0, a1, a0};
    end
    @(negedge clk);
    capture(n - 1);
  endtask

  task automatic check_outs_zero(input string name);
    check_vec({name, ".active"}, 32'(act1), 0);
    check_vec({name, ".valid"},  32'(val1), 0);
    check_vec({name, ".sync"},   32'(syn1), 0);
    check_vec({name, ".data"},   32'(dat1), 0);
    check_vec({name, ".errsot"}, 32'(esot1), 0);
    check_vec({name, ".errsync"}, 32'(esync1), 0);
  endtask

  // Single-lane burst: sync's last bit lands on edge c, groups follow at c+5, c+9, ...
  task automatic burst1(input string name, input logic [7:0] syncb, input int lead, input int exp_err);
    int c;
    c = (lead + 7) / 2;
    clear_stims();
    load_lane(0, lead, syncb);
    en1 = 1'b1;
    run_cycles(c + 31);
    en1 = 1'b0;
    check_vec({name, ".nvalid"}, 32'(got1.size()), 7);
    for (int j = 0; j < 7 && j < got1.size(); j++) begin
      check_vec($sformatf("%s.byte%0d", name, j), 32'(got1[j]), 32'(DATA[j]));
      check_vec($sformatf("%s.edge%0d", name, j), 32'(edg1[j]), 32'(c + 5 + 4 * j));
      check_vec($sformatf("%s.sync%0d", name, j), 32'(sy1[j]), 32'(j == 0));
      check_vec($sformatf("%s.act%0d", name, j), 32'(ac1[j]), 1);
    end
    check_vec({name, ".errsot_pulses"}, 32'(nerr1), 32'(exp_err));
    @(negedge clk);
    check_vec({name, ".drop_active"}, 32'(act1), 0);
    check_vec({name, ".drop_valid"},  32'(val1), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outs_zero("reset");
    check_vec("reset.data2", 32'(dat2), 0);
    rst_n = 1'b1;
    @(negedge clk);

    burst1("t1", 8'hB8, 8, 0);
    burst1("t2", 8'hB8, 9, 0);
    burst1("t3", 8'hF8, 8, 1);
    check_vec("t3.strict_novalid", 32'(nval0), 0);

    clear_stims();
    load_lane(0, 8, 8'hF8);
    en1 = 1'b1;
    run_cycles(75);
    en1 = 1'b0;
    check_vec("t3b.errsync_early", 32'(es0[60]), 0);
    check_vec("t3b.errsync_late",  32'(es0[70]), 1);
    check_vec("t3b.novalid",       32'(nval0), 0);
    @(negedge clk);

    clear_stims();
    push_bit(0, 1'b0); push_bit(0, 1'b0); push_bit(0, 1'b1);
    push_bit(0, 1'b0); push_bit(0, 1'b0); push_bit(0, 1'b1);
    en1 = 1'b1;
    run_cycles(75);
    en1 = 1'b0;
    check_vec("t4.errsync_early", 32'(es1[60]), 0);
    check_vec("t4.errsync_late",  32'(es1[70]), 1);
    check_vec("t4.novalid",       32'(got1.size()), 0);
    @(negedge clk);
    check_vec("t4.errsync_cleared", 32'(esync1), 0);
    burst1("t4.recover", 8'hB8, 8, 0);

    clear_stims();
    load_lane(1, 8, 8'hB8);
    load_lane(2, 16, 8'hB8);
    en2 = 1'b1;
    run_cycles(42);
    en2 = 1'b0;
    check_vec("t5.nvalid", 32'(got2.size()), 7);
    for (int j = 0; j < 7 && j < got2.size(); j++) begin
      check_vec($sformatf("t5.group%0d", j), 32'(got2[j]), 32'({DATA[j], DATA[j]}));
      check_vec($sformatf("t5.edge%0d", j), 32'(edg2[j]), 32'(16 + 4 * j));
    end
    @(negedge clk);

    clear_stims();
    load_lane(1, 8, 8'hB8);
    load_lane(2, 40, 8'hB8);
    en2 = 1'b1;
    run_cycles(35);
    en2 = 1'b0;
    check_vec("t5b.errsync_early", 32'(es2[20]), 0);
    check_vec("t5b.errsync_ovf",   32'(es2[32]), 1);
    check_vec("t5b.novalid",       32'(got2.size()), 0);
    @(negedge clk);
    check_vec("t5b.errsync_cleared", 32'(esync2), 0);

    clear_stims();
    load_lane(0, 8, 8'hB8);
    en1 = 1'b1;
    run_cycles(15);
    check_vec("t6.first_byte", 32'(got1.size() > 0 ? got1[0] : 8'hxx), 32'h0CF);
    en1 = 1'b0;
    @(negedge clk);
    check_outs_zero("t6.drop");
    clear_stims();
    run_cycles(8);
    check_vec("t6.no_partial", 32'(got1.size()), 0);

    clear_stims();
    load_lane(0, 8, 8'hB8);
    en1 = 1'b1;
    run_cycles(15);
    check_vec("t6b.active_before", 32'(act1), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_outs_zero("t6b.reset");
    rst_n = 1'b1;
    en1 = 1'b0;
    clear_stims();
    run_cycles(6);
    check_vec("t6b.no_valid_after", 32'(got1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
